// File: rtl/decoder3_to_8_pipe.sv
// Pipelined binary-to-one-hot decoder behind a 2-entry skid buffer (main + skid).
// in_ready comes straight from a flop, so there is no combinational path from out_ready back to in_ready.
module decoder3_to_8_pipe #(
    parameter int width = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(width)-1:0] in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [width-1:0]         out,
    output logic                     out_err,
    output logic [15:0]              xfer_cnt
);

    localparam int IW = $clog2(width);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [width-1:0]   main_word_q, main_word_d;
    logic               main_err_q, main_err_d;
    logic [width-1:0]   skid_word_q, skid_word_d;
    logic               skid_err_q, skid_err_d;
    logic [15:0]        xfer_cnt_q, xfer_cnt_d;

    logic               in_xfer;
    logic               out_xfer;
    logic [width:0]     dec;

    // Result is {err, one-hot word}; err is set exactly when no output line matched the index.
    function automatic logic [width:0] decode(input logic [IW-1:0] idx);
        logic [width:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r[i] = (idx == IW'(i));
        end
        r[width] = ~|r[width-1:0];
        return r;
    endfunction

    assign dec       = decode(in);
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign out       = main_word_q;
    assign out_err   = main_err_q;
    assign xfer_cnt  = xfer_cnt_q;

    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d     = state_q;
        main_word_d = main_word_q;
        main_err_d  = main_err_q;
        skid_word_d = skid_word_q;
        skid_err_d  = skid_err_q;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_word_d = dec[width-1:0];
                    main_err_d  = dec[width];
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_word_d = dec[width-1:0];
                    main_err_d  = dec[width];
                end else if (in_xfer) begin
                    skid_word_d = dec[width-1:0];
                    skid_err_d  = dec[width];
                    state_d     = TWO;
                end else if (out_xfer) begin
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain from skid into main can happen.
                if (out_xfer) begin
                    main_word_d = skid_word_q;
                    main_err_d  = skid_err_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        in_ready_d = (state_d != TWO);
        xfer_cnt_d = xfer_cnt_q + {15'd0, out_xfer};
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // The skid register is reset as well so a mid-operation reset leaves nothing stale behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            main_word_q <= '0;
            main_err_q  <= 1'b0;
            skid_word_q <= '0;
            skid_err_q  <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_word_q <= main_word_d;
            main_err_q  <= main_err_d;
            skid_word_q <= skid_word_d;
            skid_err_q  <= skid_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

endmodule
